// File: rtl/ex_mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer holding HI/LO next to the EX ALU.
// Define MDU_SIGNED_EN to execute MULT/DIV as signed operations.

`ifndef OP_LENGTH
`define OP_LENGTH 4
`endif
`ifndef CMD_MULT
`define CMD_MULT  4'd1
`endif
`ifndef CMD_MULTU
`define CMD_MULTU 4'd2
`endif
`ifndef CMD_DIV
`define CMD_DIV   4'd3
`endif
`ifndef CMD_DIVU
`define CMD_DIVU  4'd4
`endif
`ifndef CMD_MTHI
`define CMD_MTHI  4'd5
`endif
`ifndef CMD_MTLO
`define CMD_MTLO  4'd6
`endif

module ex_mdu_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`OP_LENGTH-1:0]  op,
    input  logic                   start,
    input  logic [WIDTH-1:0]       regaData,
    input  logic [WIDTH-1:0]       regbData,
    input  logic                   flush,
    output logic [WIDTH-1:0]       hi,
    output logic [WIDTH-1:0]       lo,
    output logic                   busy,
    output logic                   stallReq,
    output logic                   done,
    output logic                   divZero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic [CNT_W-1:0]     cnt;

    logic                 is_mul, is_div;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_top, div_diff;
    logic [2*WIDTH-1:0]   mul_nxt, div_nxt, mul_res;
    logic [WIDTH-1:0]     quo, rmd;

`ifdef MDU_SIGNED_EN
    logic                 a_neg, b_neg, neg_q, neg_r;

    function automatic logic [WIDTH-1:0] fix_word(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_prod(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction
`endif

    always_comb begin
        is_mul = (op == `CMD_MULT) || (op == `CMD_MULTU);
        is_div = (op == `CMD_DIV)  || (op == `CMD_DIVU);
`ifdef MDU_SIGNED_EN
        a_neg  = ((op == `CMD_MULT) || (op == `CMD_DIV)) && regaData[WIDTH-1];
        b_neg  = ((op == `CMD_MULT) || (op == `CMD_DIV)) && regbData[WIDTH-1];
        a_mag  = fix_word(regaData, a_neg);
        b_mag  = fix_word(regbData, b_neg);
`else
        a_mag  = regaData;
        b_mag  = regbData;
`endif
    end

    assign stallReq = (state == S_MUL) || (state == S_DIV) ||
                      ((state == S_IDLE) && start && (is_mul || is_div));

    // Shift-add multiply step; the carry of the upper-half add re-enters at the MSB.
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    end

    // Restoring divide step; the bit shifted out of the remainder joins the compare,
    // and the sign of the WIDTH+1 bit difference is the "did not fit" indicator.
    always_comb begin
        div_top  = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_top - {1'b0, opnd};
        div_nxt  = {acc[2*WIDTH-2:0], 1'b0};
        if (!div_diff[WIDTH]) begin
            div_nxt[2*WIDTH-1:WIDTH] = div_diff[WIDTH-1:0];
            div_nxt[0]               = 1'b1;
        end
    end

    always_comb begin
`ifdef MDU_SIGNED_EN
        mul_res = fix_prod(mul_nxt, neg_q);
        quo     = fix_word(div_nxt[WIDTH-1:0], neg_q);
        rmd     = fix_word(div_nxt[2*WIDTH-1:WIDTH], neg_r);
`else
        mul_res = mul_nxt;
        quo     = div_nxt[WIDTH-1:0];
        rmd     = div_nxt[2*WIDTH-1:WIDTH];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divZero <= 1'b0;
            cnt     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (op == `CMD_MTHI) begin
                            hi <= regaData;
                        end else if (op == `CMD_MTLO) begin
                            lo <= regaData;
                        end else if (is_mul) begin
                            acc   <= {{WIDTH{1'b0}}, b_mag};
                            opnd  <= a_mag;
                            cnt   <= '0;
                            state <= S_MUL;
                            busy  <= 1'b1;
`ifdef MDU_SIGNED_EN
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
`endif
                        end else if (is_div) begin
                            if (regbData == '0) begin
                                hi      <= regaData;
                                lo      <= '1;
                                divZero <= 1'b1;
                                state   <= S_DONE;
                                done    <= 1'b1;
                            end else begin
                                acc   <= {{WIDTH{1'b0}}, a_mag};
                                opnd  <= b_mag;
                                cnt   <= '0;
                                state <= S_DIV;
                                busy  <= 1'b1;
`ifdef MDU_SIGNED_EN
                                neg_q <= a_neg ^ b_neg;
                                neg_r <= a_neg;
`endif
                            end
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= (state == S_MUL) ? mul_nxt : div_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH-1)) begin
                            if (state == S_MUL) begin
                                {hi, lo} <= mul_res;
                            end else begin
                                lo      <= quo;
                                hi      <= rmd;
                                divZero <= 1'b0;
                            end
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Scoreboard bench for ex_mdu_ctrl: randomized ops checked against an arithmetic model.

`ifndef OP_LENGTH
`define OP_LENGTH 4
`endif
`ifndef CMD_MULT
`define CMD_MULT  4'd1
`endif
`ifndef CMD_MULTU
`define CMD_MULTU 4'd2
`endif
`ifndef CMD_DIV
`define CMD_DIV   4'd3
`endif
`ifndef CMD_DIVU
`define CMD_DIVU  4'd4
`endif
`ifndef CMD_MTHI
`define CMD_MTHI  4'd5
`endif
`ifndef CMD_MTLO
`define CMD_MTLO  4'd6
`endif

module tb_ex_mdu_ctrl;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  start = 1'b0;
    logic                  flush = 1'b0;
    logic [`OP_LENGTH-1:0] op = '0;
    logic [W-1:0]          regaData = '0;
    logic [W-1:0]          regbData = '0;
    logic [W-1:0]          hi, lo;
    logic                  busy, stallReq, done, divZero;

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     done_seen = 0;
    exp_t   sbq[$];
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dz = 1'b0;

    ex_mdu_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .op(op), .start(start),
        .regaData(regaData), .regbData(regbData), .flush(flush),
        .hi(hi), .lo(lo), .busy(busy), .stallReq(stallReq),
        .done(done), .divZero(divZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_md(input logic [`OP_LENGTH-1:0] o);
        return (o == `CMD_MULT) || (o == `CMD_MULTU) || (o == `CMD_DIV) || (o == `CMD_DIVU);
    endfunction

    task automatic push(input int c);
        exp_t e;
        e.hi = m_hi; e.lo = m_lo; e.dz = m_dz; e.cyc = c;
        sbq.push_back(e);
    endtask

    // Architectural effect of one accepted op, from plain arithmetic.
    task automatic predict(input logic [`OP_LENGTH-1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int c0);
        logic [63:0] p, qv, rv;
        longint      sa, sb;
        bit          sg;
        sg = 1'b0;
`ifdef MDU_SIGNED_EN
        sg = (o == `CMD_MULT) || (o == `CMD_DIV);
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == `CMD_MTHI) begin
            m_hi = a;
        end else if (o == `CMD_MTLO) begin
            m_lo = a;
        end else if ((o == `CMD_MULT) || (o == `CMD_MULTU)) begin
            if (sg) p = 64'(sa * sb);
            else    p = {32'b0, a} * {32'b0, b};
            m_hi = p[63:32];
            m_lo = p[31:0];
            push(c0 + W + 1);
        end else if ((o == `CMD_DIV) || (o == `CMD_DIVU)) begin
            if (b == '0) begin
                m_hi = a; m_lo = '1; m_dz = 1'b1;
                push(c0 + 1);
            end else begin
                if (sg) begin
                    qv = 64'(sa / sb);
                    rv = 64'(sa % sb);
                    m_lo = qv[31:0];
                    m_hi = rv[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
                m_dz = 1'b0;
                push(c0 + W + 1);
            end
        end
    endtask

    task automatic run_op(input logic [`OP_LENGTH-1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit junk);
        int seen0;
        bit fin;
        logic [`OP_LENGTH-1:0] jop;
        @(negedge clk);
        op = o; regaData = a; regbData = b; start = 1'b1;
        seen0 = done_seen;
        predict(o, a, b, cyc);
        #1 chk("stall_issue", stallReq, is_md(o));
        @(negedge clk);
        start = 1'b0;
        if (!is_md(o)) begin
            #1;
            chk("idle_hi", hi, m_hi);
            chk("idle_lo", lo, m_lo);
            chk("idle_stall", stallReq, 0);
            return;
        end
        fin = 1'b0;
        for (int i = 0; i < W + 4 && !fin; i++) begin
            if (done_seen != seen0) begin
                chk("stall_done", stallReq, 0);
                chk("busy_done", busy, 0);
                fin = 1'b1;
            end else begin
                chk("stall_busy", stallReq, 1);
                chk("busy_run", busy, 1);
                if (junk) begin
                    jop = `OP_LENGTH'($urandom_range(1, 4));
                    start = 1'($urandom_range(0, 1));
                    op = jop; regaData = $urandom; regbData = $urandom;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!fin) begin
            chk("done_timeout", 0, 1);
            sbq.delete();
        end
    endtask

    task automatic abort_test(input bit use_rst);
        run_op(`CMD_MTHI, 32'h1234, 32'h0, 1'b0);
        @(negedge clk);
        op = `CMD_MULTU; regaData = 32'd3; regbData = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        if (use_rst) rst = 1'b0;
        else         flush = 1'b1;
        #1 chk("abort_stall_c10", stallReq, 1);
        @(negedge clk);
        rst = 1'b1; flush = 1'b0;
        if (use_rst) begin
            m_hi = '0; m_lo = '0; m_dz = 1'b0;
        end
        #1;
        chk("abort_stall_c11", stallReq, 0);
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, m_hi);
        chk("abort_lo", lo, m_lo);
        chk("abort_dz", divZero, m_dz);
        repeat (W + 5) @(negedge clk);
        chk("abort_hi_late", hi, m_hi);
        chk("abort_lo_late", lo, m_lo);
    endtask

    // Monitor: every done pulse retires the oldest expected result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                done_seen++;
                if (sbq.size() == 0) begin
                    chk("spurious_done", done, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("res_hi", hi, e.hi);
                    chk("res_lo", lo, e.lo);
                    chk("res_divZero", divZero, e.dz);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [`OP_LENGTH-1:0] ro;
        logic [W-1:0] ra, rb;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_divZero", divZero, 0);
        chk("rst_stall", stallReq, 0);
        rst = 1'b1;

        run_op(`CMD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("tp_multu_hi", hi, 32'hFFFF_FFFE);
        chk("tp_multu_lo", lo, 32'h0000_0001);
        run_op(`CMD_DIVU, 32'd100, 32'd7, 1'b0);
        chk("tp_divu_lo", lo, 32'h0000_000E);
        chk("tp_divu_hi", hi, 32'h0000_0002);
        run_op(`CMD_DIVU, 32'd5, 32'd0, 1'b0);
        chk("tp_div0_hi", hi, 32'h0000_0005);
        chk("tp_div0_lo", lo, 32'hFFFF_FFFF);
        chk("tp_div0_dz", divZero, 1);
        run_op(`CMD_DIVU, 32'd9, 32'd3, 1'b0);
        chk("tp_div93_dz", divZero, 0);
        chk("tp_div93_lo", lo, 32'd3);
`ifdef MDU_SIGNED_EN
        run_op(`CMD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("tp_mult_hi", hi, 32'hFFFF_FFFF);
        chk("tp_mult_lo", lo, 32'hFFFF_FFF1);
        run_op(`CMD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("tp_div_lo", lo, 32'hFFFF_FFFD);
        chk("tp_div_hi", hi, 32'hFFFF_FFFF);
`else
        run_op(`CMD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("tp_div_lo", lo, 32'h7FFF_FFFC);
        chk("tp_div_hi", hi, 32'h0000_0001);
`endif
        run_op(`CMD_MULTU, 32'd1234567, 32'd89, 1'b1);
        run_op(`CMD_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1);

        abort_test(1'b0);
        abort_test(1'b1);

        // flush together with start in IDLE latches nothing
        @(negedge clk);
        op = `CMD_MTHI; regaData = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        op = `CMD_MULTU; regaData = 32'd7; regbData = 32'd7;
        #1 chk("flush_mt_hi", hi, m_hi);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1 chk("flush_mul_busy", busy, 0);
        chk("flush_mul_stall", stallReq, 0);

        // reset wins over a simultaneous MT op
        run_op(`CMD_MTLO, 32'h5555_AAAA, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0; op = `CMD_MTLO; regaData = 32'h1111_2222; start = 1'b1;
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        #1 chk("rst_vs_mt_lo", lo, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: ro = `CMD_MULT;
                1: ro = `CMD_MULTU;
                2: ro = `CMD_DIV;
                3: ro = `CMD_DIVU;
                4: ro = `CMD_MTHI;
                5: ro = `CMD_MTLO;
                6: ro = `CMD_DIVU;
                default: ro = `OP_LENGTH'($urandom_range(7, 15));
            endcase
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mdu_ctrl.md
Name: ex_mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer beside the single-cycle EX ALU.
- Accepts MULT/MULTU/DIV/DIVU ops issued to EX and runs a WIDTH-iteration shift-add multiply or restoring divide.
- Holds the architectural HI/LO registers.
- Raises stallReq so the pipeline freezes until the result is committed.

Parameters:
- WIDTH, 32, operand/HI/LO width (equals `REG_LENGTH).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-low (rst==0 at a rising edge resets).
- op  input  `OP_LENGTH  decoded op; decodes `CMD_MULT, `CMD_MULTU, `CMD_DIV, `CMD_DIVU, `CMD_MTHI, `CMD_MTLO.
- start  input  1  op/operands valid this cycle.
- regaData  input  WIDTH  rs operand (multiplicand/dividend/MT data).
- regbData  input  WIDTH  rt operand (multiplier/divisor).
- flush  input  1  abort in-flight operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  registered; high in MUL/DIV states.
- stallReq  output  1  pipeline stall request.
- done  output  1  one-cycle result-committed pulse.
- divZero  output  1  sticky flag, last divide had a zero divisor.

Behaviour:
- Reset (rst==0 at an edge, any state): state=IDLE; hi=0, lo=0, busy=0, done=0, divZero=0, counter=0. Any in-flight operation is discarded.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start & MT op: `CMD_MTHI loads hi=regaData, `CMD_MTLO loads lo=regaData at the edge. Stay in IDLE, no stall.
  - start & MULT/MULTU: latch operands into a 2*WIDTH accumulator {0, multiplier} and a multiplicand register; counter=0; go to MUL.
  - start & DIV/DIVU with regbData!=0: latch a 2*WIDTH remainder {0, dividend} and the divisor; go to DIV.
  - start & DIV/DIVU with regbData==0: go straight to DONE with hi=dividend, lo={WIDTH{1'b1}}, divZero=1.
  - Any other op, or start low: no action.
- stallReq = (state==MUL | state==DIV) | (state==IDLE & start & op in {MULT,MULTU,DIV,DIVU}).
  - The issuing cycle stalls combinationally; the DONE cycle does not stall.
- MUL, one iteration per cycle:
  - If acc[0], acc[2W-1:W] += multiplicand (WIDTH+1 bit sum, carry kept).
  - Then shift acc right 1, with the carry entering the MSB.
- DIV, one iteration per cycle (restoring):
  - Shift rem left 1.
  - If rem[2W-1:W] >= divisor: subtract divisor from it and set rem[0]=1.
- Iteration count:
  - counter increments each iteration.
  - The iteration performed with counter==WIDTH-1 is the last; the state then moves to DONE.
- Commit at the edge entering DONE:
  - MUL: {hi,lo}=acc.
  - DIV: lo=quotient, hi=remainder; divZero cleared.
- DONE, lasts one cycle: done=1, busy=0, then IDLE unconditionally.
  - A start in DONE is ignored; the pipeline re-presents it because the stall released only this cycle.
- Latency: start sampled in cycle 0 -> MUL/DIV in cycles 1..WIDTH -> DONE in cycle WIDTH+1.
  - hi/lo are valid and done=1 in cycle WIDTH+1. Divide-by-zero: DONE in cycle 1.
- start while busy: ignored; operands are not re-latched.
- flush in MUL/DIV: next state IDLE, hi/lo/divZero unchanged, no done pulse, stallReq drops the next cycle.
- flush in IDLE/DONE: no effect. In DONE the commit has already happened.
- flush and start together in IDLE: flush wins, nothing is latched.
- Simultaneous MT op and reset: reset wins.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined:
  - MULT/DIV take operand magnitudes at latch.
  - Result sign = sign(a)^sign(b).
  - MULT negates the 2W product when negative.
  - DIV negates the quotient when signs differ; the remainder takes the dividend's sign.
  - Corrections are applied at the commit edge, with no extra cycle.
- Not defined: `CMD_MULT/`CMD_DIV are executed exactly as MULTU/DIVU, and the sign logic is absent.

Test Plan:
- MULTU regaData=0xFFFFFFFF, regbData=0xFFFFFFFF -> stallReq high cycles 0..32; cycle 33: done=1, hi=0xFFFFFFFE, lo=0x00000001, stallReq=0.
- DIVU 100/7 -> cycle 33: lo=0x0000000E, hi=0x00000002, divZero=0.
- DIVU 5/0 -> cycle 1: done=1, hi=0x00000005, lo=0xFFFFFFFF, divZero=1. A following DIVU 9/3 clears divZero (lo=3, hi=0).
- MDU_SIGNED_EN: MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Without the macro, DIV 0xFFFFFFF9/2 -> lo=0x7FFFFFFC, hi=1.
- MTHI 0x1234, then MULTU 3*4 with flush in cycle 10 -> no done; hi=0x1234, lo unchanged; stallReq=0 from cycle 11. Repeat with rst=0 in cycle 10 instead -> hi=lo=0, busy=0.
- start re-asserted in cycles 1..32 with different operands -> ignored; result matches the first operands.
